// File: rtl/systolic_pkg.sv
// Shared types and helpers for the NxN output-stationary systolic multiplier.
package systolic_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FEED  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Accumulator width that can hold N products of two DW-bit operands
  // without wrapping, in either signedness.
  function automatic int acc_width(input int n, input int dw);
    return 2 * dw + $clog2(n);
  endfunction

  // LSB position of element (row,col) in a row-major flat vector of n x n
  // elements that are w bits wide.
  function automatic int elem_lo(input int row, input int col, input int n, input int w);
    return (row * n + col) * w;
  endfunction

endpackage

// File: rtl/systolic_mm_nxn_if.sv
// Operand / result handshake bundle between loader, multiplier and consumer.
interface systolic_mm_nxn_if
  import systolic_pkg::*;
#(
  parameter int N  = 3,
  parameter int DW = 8,
  parameter int AW = acc_width(N, DW)
) ();

  logic                in_valid;
  logic                in_ready;
  logic                signed_mode;
  logic [N*N*DW-1:0]   a_flat;
  logic [N*N*DW-1:0]   b_flat;
  logic                out_valid;
  logic                out_ready;
  logic [N*N*AW-1:0]   c_flat;
  logic                busy;

  // Producer/consumer side: drives operands and result acceptance.
  modport master (
    output in_valid, signed_mode, a_flat, b_flat, out_ready,
    input  in_ready, out_valid, c_flat, busy
  );

  // Multiplier side.
  modport slave (
    input  in_valid, signed_mode, a_flat, b_flat, out_ready,
    output in_ready, out_valid, c_flat, busy
  );

endinterface

// File: rtl/systolic_pe.sv
// One processing element: forwards A right and B down, accumulates A*B.
module systolic_pe #(
  parameter int DW = 8,
  parameter int AW = 18
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          signed_mode,
  input  logic [DW-1:0] a_in,
  input  logic [DW-1:0] b_in,
  output logic [DW-1:0] a_out,
  output logic [DW-1:0] b_out,
  output logic [AW-1:0] acc
);

  logic [DW-1:0] a_q;
  logic [DW-1:0] b_q;
  logic [AW-1:0] acc_q;
  logic [AW-1:0] prod;

  // Widen an operand to the accumulator width; sign-extend only in signed mode.
  function automatic logic [AW-1:0] ext(input logic [DW-1:0] v, input logic sm);
    return {{(AW-DW){sm & v[DW-1]}}, v};
  endfunction

  // Low AW bits of the product are exact modulo 2^AW for both signednesses.
  assign prod = ext(a_in, signed_mode) * ext(b_in, signed_mode);

  // Operand forwarding and multiply-accumulate; clr starts a new matrix.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
    end else begin
      a_q   <= a_in;
      b_q   <= b_in;
      acc_q <= acc_q + prod;
    end
  end

  assign a_out = a_q;
  assign b_out = b_q;
  assign acc   = acc_q;

endmodule

// File: rtl/systolic_mm_nxn.sv
// NxN output-stationary systolic matrix multiplier with valid/ready handshakes.
module systolic_mm_nxn
  import systolic_pkg::*;
#(
  parameter int N  = 3,
  parameter int DW = 8,
  parameter int AW = acc_width(N, DW)
) (
  input logic              clk,
  input logic              rst,
  systolic_mm_nxn_if.slave bus
);

  localparam int            CW         = $clog2(3 * N);
  localparam logic [CW-1:0] FEED_LAST  = CW'(3 * N - 3);
  localparam logic [CW-1:0] DRAIN_LAST = CW'(N - 1);

  state_e              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [N*N*DW-1:0]   a_q, b_q;
  logic                sm_q;
  logic [N*N*AW-1:0]   c_q, c_d;
  logic                accept;
  logic                in_ready_c, out_valid_c, busy_c;

  logic [DW-1:0]       a_edge [N];
  logic [DW-1:0]       b_edge [N];
  logic [DW-1:0]       a_pe   [N][N];
  logic [DW-1:0]       b_pe   [N][N];
  logic [AW-1:0]       acc_pe [N][N];

  assign accept = in_ready_c && bus.in_valid;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic: IDLE -> FEED (3N-2) -> DRAIN (N) -> DONE -> IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.in_valid)         state_d = FEED;
      FEED:    if (cnt_q == FEED_LAST)   state_d = DRAIN;
      DRAIN:   if (cnt_q == DRAIN_LAST)  state_d = DONE;
      DONE:    if (bus.out_ready)        state_d = IDLE;
      default:                           state_d = IDLE;
    endcase
  end

  // Moore outputs decoded from the state.
  always_comb begin
    in_ready_c  = (state_q == IDLE);
    busy_c      = (state_q == FEED) || (state_q == DRAIN);
    out_valid_c = (state_q == DONE);
  end

  // Phase counter: restarts at 0 on entry to FEED and to DRAIN.
  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (state_q == IDLE || state_q == DONE)             cnt_d = '0;
    else if (state_q == FEED && cnt_q == FEED_LAST)     cnt_d = '0;
  end

  // Operand latch, counter and result capture at the DRAIN -> DONE edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      a_q   <= '0;
      b_q   <= '0;
      sm_q  <= 1'b0;
      c_q   <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (accept) begin
        a_q  <= bus.a_flat;
        b_q  <= bus.b_flat;
        sm_q <= bus.signed_mode;
      end
      if (state_q == DRAIN && cnt_q == DRAIN_LAST) c_q <= c_d;
    end
  end

  // Skewed edge feeders: row i gets A[i][cnt-i], column j gets B[cnt-j][j],
  // zero outside the valid window so padding contributes nothing.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      a_edge[i] = '0;
      b_edge[i] = '0;
      if (state_q == FEED && int'(cnt_q) >= i && int'(cnt_q) - i < N) begin
        a_edge[i] = a_q[elem_lo(i, int'(cnt_q) - i, N, DW) +: DW];
        b_edge[i] = b_q[elem_lo(int'(cnt_q) - i, i, N, DW) +: DW];
      end
    end
  end

  // Pack the accumulator grid into row-major result order.
  always_comb begin
    c_d = '0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        c_d[elem_lo(i, j, N, AW) +: AW] = acc_pe[i][j];
      end
    end
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_row
    for (genvar gj = 0; gj < N; gj++) begin : g_col
      logic [DW-1:0] a_in_w;
      logic [DW-1:0] b_in_w;

      if (gj == 0) begin : g_a_edge
        assign a_in_w = a_edge[gi];
      end else begin : g_a_link
        assign a_in_w = a_pe[gi][gj-1];
      end

      if (gi == 0) begin : g_b_edge
        assign b_in_w = b_edge[gj];
      end else begin : g_b_link
        assign b_in_w = b_pe[gi-1][gj];
      end

      systolic_pe #(.DW(DW), .AW(AW)) u_pe (
        .clk         (clk),
        .rst         (rst),
        .clr         (accept),
        .signed_mode (sm_q),
        .a_in        (a_in_w),
        .b_in        (b_in_w),
        .a_out       (a_pe[gi][gj]),
        .b_out       (b_pe[gi][gj]),
        .acc         (acc_pe[gi][gj])
      );
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;
  assign bus.busy      = busy_c;
  assign bus.c_flat    = c_q;

endmodule

// File: tb/tb_systolic_mm_nxn.sv
// Scoreboard bench for systolic_mm_nxn at N=3 and N=4.
module tb_systolic_mm_nxn;

  localparam int AW = 18;

  logic clk = 1'b0;
  logic rst;
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  systolic_mm_nxn_if #(.N(3), .DW(8)) bus3 ();
  systolic_mm_nxn_if #(.N(4), .DW(8)) bus4 ();

  systolic_mm_nxn #(.N(3), .DW(8)) u_dut3 (.clk(clk), .rst(rst), .bus(bus3));
  systolic_mm_nxn #(.N(4), .DW(8)) u_dut4 (.clk(clk), .rst(rst), .bus(bus4));

  logic [161:0] exp3_q[$];
  logic [287:0] exp4_q[$];
  int           t4_q[$];
  logic [71:0]  ra, rb;
  int           nn;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Plain matrix product reference; element (i,j) of width AW.
  function automatic logic [287:0] ref_c(input int n, input logic [127:0] a,
                                         input logic [127:0] b, input logic sm);
    logic [287:0] r;
    longint s, x, y;
    logic [7:0] av, bv;
    r = '0;
    for (int i = 0; i < n; i++) begin
      for (int j = 0; j < n; j++) begin
        s = 0;
        for (int k = 0; k < n; k++) begin
          av = a[(i*n+k)*8 +: 8];
          bv = b[(k*n+j)*8 +: 8];
          x = sm ? longint'($signed(av)) : longint'(av);
          y = sm ? longint'($signed(bv)) : longint'(bv);
          s += x * y;
        end
        r[(i*n+j)*AW +: AW] = s[AW-1:0];
      end
    end
    return r;
  endfunction

  function automatic logic [71:0] fill3(input logic [7:0] v);
    logic [71:0] r;
    for (int i = 0; i < 9; i++) r[i*8 +: 8] = v;
    return r;
  endfunction

  function automatic logic [71:0] ident3();
    logic [71:0] r;
    r = '0;
    for (int i = 0; i < 3; i++) r[(i*3+i)*8 +: 8] = 8'd1;
    return r;
  endfunction

  function automatic logic [71:0] seq3();
    logic [71:0] r;
    for (int i = 0; i < 9; i++) r[i*8 +: 8] = 8'(i + 1);
    return r;
  endfunction

  task automatic chk_c3(input string tag, input logic [161:0] e);
    for (int i = 0; i < 9; i++)
      chk($sformatf("%s_c[%0d]", tag, i), bus3.c_flat[i*AW +: AW], e[i*AW +: AW]);
  endtask

  // One N=3 operation; hold = cycles out_ready stays low after out_valid.
  task automatic run3(input string tag, input logic [71:0] a, input logic [71:0] b,
                      input logic sm, input int hold);
    int n;
    logic [161:0] e;
    logic [287:0] r;
    n = 0;
    while (!bus3.in_ready && n < 100) begin @(posedge clk); #1; n++; end
    chk({tag, "_rdy"}, bus3.in_ready, 1);
    bus3.a_flat = a; bus3.b_flat = b; bus3.signed_mode = sm; bus3.in_valid = 1'b1;
    @(posedge clk); #1;
    bus3.in_valid = 1'b0;
    bus3.signed_mode = ~sm;
    bus3.a_flat = ~a;
    bus3.b_flat = ~b;
    r = ref_c(3, 128'(a), 128'(b), sm);
    exp3_q.push_back(r[161:0]);
    n = 0;
    while (!bus3.out_valid && n < 60) begin
      chk({tag, "_busy"}, {bus3.busy, bus3.in_ready}, 2'b10);
      @(posedge clk); #1; n++;
    end
    chk({tag, "_lat"}, n, 10);
    e = exp3_q.pop_front();
    chk_c3(tag, e);
    for (int h = 0; h < hold; h++) begin
      bus3.in_valid = (h == 5);
      @(posedge clk); #1;
      chk({tag, "_hold"}, {bus3.out_valid, bus3.in_ready, bus3.c_flat == e}, 3'b101);
    end
    bus3.in_valid  = 1'b0;
    bus3.out_ready = 1'b1;
    @(posedge clk); #1;
    bus3.out_ready = 1'b0;
    chk({tag, "_post"}, {bus3.out_valid, bus3.in_ready, bus3.busy, bus3.c_flat == e}, 4'b0101);
  endtask

  task automatic drv4();
    logic [127:0] a, b;
    logic [287:0] r;
    logic sm;
    int n;
    for (int op = 0; op < 50; op++) begin
      for (int i = 0; i < 16; i++) begin
        a[i*8 +: 8] = 8'($urandom);
        b[i*8 +: 8] = 8'($urandom);
      end
      sm = 1'($urandom);
      if (op == 0) begin a = '1; b = '1; sm = 1'b0; end
      if (op == 1) begin a = {16{8'h80}}; b = {16{8'h80}}; sm = 1'b1; end
      n = 0;
      while (!bus4.in_ready && n < 100) begin @(posedge clk); #1; n++; end
      chk("drv4_rdy", bus4.in_ready, 1);
      bus4.a_flat = a; bus4.b_flat = b; bus4.signed_mode = sm; bus4.in_valid = 1'b1;
      @(posedge clk); #1;
      bus4.in_valid = 1'b0;
      r = ref_c(4, a, b, sm);
      exp4_q.push_back(r);
      t4_q.push_back(cyc);
    end
  endtask

  task automatic mon4();
    int got, guard, t;
    logic [287:0] e;
    got = 0;
    guard = 0;
    while (got < 50 && guard < 2000) begin
      @(posedge clk); #1; guard++;
      if (bus4.out_valid) begin
        if (exp4_q.size() == 0) begin
          chk("mon4_unexpected", exp4_q.size(), 1);
        end else begin
          e = exp4_q.pop_front();
          t = t4_q.pop_front();
          chk($sformatf("lat4_op%0d", got), cyc - t, 14);
          for (int i = 0; i < 16; i++)
            chk($sformatf("c4_op%0d[%0d]", got, i), bus4.c_flat[i*AW +: AW], e[i*AW +: AW]);
          got++;
        end
      end
    end
    chk("mon4_count", got, 50);
  endtask

  initial begin
    rst = 1'b1;
    bus3.in_valid = 1'b0; bus3.out_ready = 1'b0; bus3.signed_mode = 1'b0;
    bus3.a_flat = '0; bus3.b_flat = '0;
    bus4.in_valid = 1'b0; bus4.out_ready = 1'b0; bus4.signed_mode = 1'b0;
    bus4.a_flat = '0; bus4.b_flat = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst3_ctl", {bus3.in_ready, bus3.out_valid, bus3.busy}, 3'b100);
    chk("rst3_c", bus3.c_flat == '0, 1);
    chk("rst4_ctl", {bus4.in_ready, bus4.out_valid, bus4.busy}, 3'b100);
    rst = 1'b0;
    @(posedge clk); #1;

    run3("ident", ident3(), seq3(), 1'b0, 0);
    chk("ident_lit0", bus3.c_flat[0 +: AW], 1);
    chk("ident_lit8", bus3.c_flat[8*AW +: AW], 9);
    run3("umax", fill3(8'hFF), fill3(8'hFF), 1'b0, 0);
    chk("umax_lit", bus3.c_flat[4*AW +: AW], 195075);
    run3("s80", fill3(8'h80), fill3(8'h80), 1'b1, 0);
    chk("s80_lit", bus3.c_flat[0 +: AW], 49152);
    run3("u80", fill3(8'h80), fill3(8'h80), 1'b0, 0);
    chk("u80_lit", bus3.c_flat[8*AW +: AW], 49152);
    run3("sneg", fill3(8'hFF), fill3(8'h01), 1'b1, 0);
    chk("sneg_lit", bus3.c_flat[2*AW +: AW], 18'h3FFFD);
    run3("uneg", fill3(8'hFF), fill3(8'h01), 1'b0, 0);
    chk("uneg_lit", bus3.c_flat[6*AW +: AW], 765);
    for (int i = 0; i < 9; i++) begin
      ra[i*8 +: 8] = 8'($urandom);
      rb[i*8 +: 8] = 8'($urandom);
    end
    run3("bp", ra, rb, 1'b1, 20);

    // Reset together with in_valid: no accept.
    bus3.a_flat = seq3(); bus3.b_flat = seq3(); bus3.in_valid = 1'b1; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; bus3.in_valid = 1'b0;
    @(posedge clk); #1;
    chk("rst_vs_valid", {bus3.in_ready, bus3.busy}, 2'b10);

    // Reset during FEED at cnt=2 discards the operation.
    bus3.a_flat = ident3(); bus3.b_flat = seq3(); bus3.signed_mode = 1'b0;
    bus3.in_valid = 1'b1;
    @(posedge clk); #1;
    bus3.in_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    chk("mid_busy", bus3.busy, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid_ctl", {bus3.in_ready, bus3.out_valid, bus3.busy}, 3'b100);
    chk("mid_c", bus3.c_flat == '0, 1);
    nn = 0;
    repeat (14) begin
      @(posedge clk); #1;
      if (bus3.out_valid) nn++;
    end
    chk("mid_noout", nn, 0);
    run3("after_rst", ident3(), seq3(), 1'b0, 0);

    // N=4 back-to-back sweep.
    bus4.out_ready = 1'b1;
    fork
      drv4();
      mon4();
    join
    chk("sb4_empty", exp4_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/systolic_mm_nxn.md
Name: systolic_mm_nxn

Overview:
Parametrised NxN output-stationary systolic matrix multiplier. It computes C = A x B for square DW-bit matrices, in either unsigned or signed two's-complement mode. It is the generalised successor of the fixed 3x3 array, and adds three things the fixed array lacks: valid/ready handshakes on input and output, selectable signedness, and overflow-free accumulator sizing. It sits between the operand-load logic and the result consumer.

Parameters:
N, 3, matrix dimension; legal range 2..8.
DW, 8, operand element width in bits.
AW, 2*DW+$clog2(N), accumulator and result element width; guarantees no overflow.

Ports:
clk  input  1  rising-edge clock.
rst  input  1  synchronous, active-high reset.
in_valid  input  1  operand matrices present on a_flat/b_flat.
in_ready  output  1  block can accept operands.
signed_mode  input  1  1 = two's-complement operands; sampled at accept.
a_flat  input  N*N*DW  matrix A, row-major; element (i,k) at bits [(i*N+k)*DW +: DW].
b_flat  input  N*N*DW  matrix B, row-major; element (k,j) at bits [(k*N+j)*DW +: DW].
out_valid  output  1  c_flat holds a complete result.
out_ready  input  1  consumer accepts the result.
c_flat  output  N*N*AW  matrix C, row-major; element (i,j) at bits [(i*N+j)*AW +: AW].
busy  output  1  high in FEED or DRAIN.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- On rst: state goes to IDLE. in_ready=1, out_valid=0, busy=0, c_flat=0. All skew registers, PE pipeline registers and accumulators are cleared. rst overrides every other input, including mid-computation; the in-flight operation is discarded and no result is produced.
- State IDLE: in_ready=1. Accept occurs when in_valid&&in_ready. On accept:
  - latch A, B and signed_mode;
  - clear all accumulators;
  - clear cycle counter cnt to 0;
  - go to FEED.
- State FEED: lasts 3N-2 cycles, cnt = 0..3N-3. At cycle cnt:
  - row edge i presents A[i][cnt-i] when 0 <= cnt-i < N, else 0;
  - column edge j presents B[cnt-j][j] under the same rule.
  - Zeros are used as padding; padding must never alter any sum.
- State DRAIN: lasts N cycles. Zeros are injected at every edge while the last operands propagate to PE(N-1,N-1). Then go to DONE.
- State DONE: out_valid=1 and c_flat is the final C. c_flat and out_valid stay stable until out_valid&&out_ready. On that handshake, the next state is IDLE, in_ready returns to 1 the following cycle, and c_flat holds its value but out_valid drops.
- in_ready=0 in FEED, DRAIN and DONE. There is no overlap of operations; in_valid is ignored in these states.
- Latency: the accept edge is cycle 0, and out_valid rises at cycle 4N-2 (N=3: cycle 10), independent of out_ready. Minimum issue interval is 4N cycles.
- PE function: each cycle a_out<=a_in, b_out<=b_in, acc<=acc+ext(a_in)*ext(b_in).
  - ext is sign-extension when signed_mode=1, zero-extension otherwise.
  - The product is 2*DW bits, extended to AW.
  - Accumulation wraps modulo 2^AW, but for legal N the AW default makes wrap unreachable.
- signed_mode changes outside the accept cycle have no effect.
- Simultaneous rst and in_valid: rst wins; no accept.

Decomposition:
- Package systolic_pkg holds:
  - state enum {IDLE, FEED, DRAIN, DONE};
  - localparam function for the default AW;
  - index helper functions for flat-vector slicing.
- Sub-module systolic_pe holds one PE. Its parameters are DW and AW. Its ports are clk, rst, clr, signed_mode, a_in, b_in, a_out, b_out and acc. The top generates the NxN grid of systolic_pe plus the skew feeders and the FSM.

Test Plan:
- Identity (N=3, unsigned): A=I, B=[1..9] row-major -> c_flat=[1..9]; out_valid rises exactly 10 cycles after accept.
- Max unsigned (N=3): all elements 255 -> every C element = 195075; no wrap at AW=18.
- Signed mode (N=3): all A=-128 (0x80), all B=-128 -> every C = 49152. The same data with signed_mode=0 gives every C = 3*128*128 = 49152; then A=0xFF, B=0x01 with signed -> C=-3 (0x3FFFD), unsigned -> C=765.
- Backpressure: hold out_ready=0 for 20 cycles after out_valid -> c_flat stable and in_ready=0 throughout. Pulse in_valid during this window -> ignored. After out_ready, in_ready=1 on the next cycle.
- Reset mid-operation: assert rst for 1 cycle during FEED cnt=2 -> next cycle in_ready=1, out_valid=0, c_flat=0. A new operation (A=I, B=[1..9]) then returns the correct [1..9].
- Parameter sweep: N=4, DW=8, random operands over 50 back-to-back operations with out_ready=1 -> every result matches the reference model, with latency 14 each.
